// File: rtl/mux_collector_4to1_if.sv
// Bundle of the collector's channel-side and output-side signals.
// The master side feeds strobes/data and the sink ready; the slave side is the collector.
interface mux_collector_4to1_if #(
  parameter int WIDTH = 1
);
  logic [3:0]         strb;
  logic [4*WIDTH-1:0] din;
  logic [WIDTH-1:0]   Y;
  logic [1:0]         Sel;
  logic               valid;
  logic               ready;
  logic [3:0]         pending;
  logic [3:0]         ovf;

  modport master (
    output strb, din, ready,
    input  Y, Sel, valid, pending, ovf
  );

  modport slave (
    input  strb, din, ready,
    output Y, Sel, valid, pending, ovf
  );
endinterface

// File: rtl/mux_collector_4to1.sv
// Four-channel round-robin collector: one holding register per channel, merged onto a
// single valid/ready output tagged with the source channel index.
module mux_collector_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mux_collector_4to1_if.slave   bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0][WIDTH-1:0]   hold_q, hold_d;
  logic [3:0]              pending_q, pending_d;
  logic [3:0]              ovf_q, ovf_d;
  logic [WIDTH-1:0]        y_q, y_d;
  logic [1:0]              sel_q, sel_d;
  logic [1:0]              ptr_q, ptr_d;
  logic                    grant_s;
  logic [1:0]              gnt_idx_s;

  // First requesting channel at or after ptr, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx   = ptr + 2'(k);
      pick  = (!found && req[idx]) ? idx : pick;
      found = found | req[idx];
    end
    return pick;
  endfunction

  // Grant decision, channel capture/overflow and output-stage next state.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    y_d       = y_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;

    // Only words already held before this edge compete; same-edge captures wait.
    grant_s   = ((state_q == ST_EMPTY) || bus.ready) && (|pending_q);
    gnt_idx_s = rr_pick(pending_q, ptr_q);

    for (int i = 0; i < 4; i++) begin
      if (bus.strb[i]) begin
        hold_d[i]    = bus.din[i*WIDTH +: WIDTH];
        pending_d[i] = 1'b1;
        if (pending_q[i] && !(grant_s && (gnt_idx_s == 2'(i)))) begin
          ovf_d[i] = 1'b1;
        end else begin
          ovf_d[i] = ovf_q[i];
        end
      end else if (grant_s && (gnt_idx_s == 2'(i))) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end

    case (state_q)
      ST_EMPTY: begin
        if (grant_s) begin
          y_d     = hold_q[gnt_idx_s];
          sel_d   = gnt_idx_s;
          ptr_d   = gnt_idx_s + 2'd1;
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (grant_s) begin
          y_d     = hold_q[gnt_idx_s];
          sel_d   = gnt_idx_s;
          ptr_d   = gnt_idx_s + 2'd1;
          state_d = ST_FULL;
        end else if (bus.ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      hold_q    <= '0;
      pending_q <= 4'b0000;
      ovf_q     <= 4'b0000;
      y_q       <= '0;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      y_q       <= y_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.Y       = y_q;
  assign bus.Sel     = sel_q;
  assign bus.valid   = (state_q == ST_FULL);
  assign bus.pending = pending_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: doc/mux_collector_4to1.md
Name: mux_collector_4to1

Overview:
Four-channel collector that merges four independent source channels onto one output channel. It is the return path for the 1-to-4 demux: the 2-bit select code tags which source each output word came from, so a downstream demux can route it back. Each channel has a one-entry holding register, a round-robin arbiter picks among pending channels, and the output stage uses a valid/ready handshake.

Parameters:
WIDTH, 1, data width per channel and of the output word.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
strb  input  4  per-channel capture strobe; strb[i] high for a cycle presents din for channel i.
din  input  4*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
Y  output  WIDTH  output data word.
Sel  output  2  source channel index of Y (0..3).
valid  output  1  Y/Sel hold a word.
ready  input  1  downstream accepts the word when valid and ready are both high on a rising edge.
pending  output  4  per-channel holding register occupied.
ovf  output  4  sticky per-channel overflow flag.

Behaviour:
- Reset, asynchronous, takes effect immediately whatever the clock is doing. It sets: Y=0, Sel=0, valid=0, pending=0, ovf=0, round-robin pointer=0. Reset during an active transfer drops all held words and the output word.
- Capture: when strb[i]=1 on an edge, hold[i] <= din slice i and pending[i] <= 1.
- Capture while pending[i]=1 and channel i is not being granted on that edge: the new data overwrites hold[i] and ovf[i] <= 1. ovf[i] stays set until reset.
- Output stage has two states:
  - EMPTY: valid=0.
  - FULL: valid=1.
- EMPTY -> FULL: on an edge where any pending bit is 1, take the grant. The granted channel is the first pending one searching from the pointer p upward, modulo 4. On that edge:
  - Y <= hold[g]; Sel <= g.
  - pending[g] <= 0.
  - p <= (g+1) mod 4.
- FULL while ready=0: Y, Sel and valid are held stable. No grant is taken.
- FULL with ready=1: the word is consumed. If any channel is pending (after this edge's captures are excluded), grant the next one in the same edge, so back-to-back words go out with no bubble. Otherwise go to EMPTY.
- Simultaneous grant and strb on the same channel: the grant takes the old hold[g]. The new data is captured, so pending[g] stays 1 and ovf[g] is not set.
- Latency: a strobe at edge k can appear on the output at edge k+1 at the earliest, because captures made on edge k are not eligible for the grant on edge k.
- With a continuously ready sink, throughput is one word per cycle.
- Pointer wrap: after a grant to channel 3, the search starts again at channel 0.
- Y and Sel are registered outputs. pending and ovf are direct register outputs.

Test Plan:
1. Reset, then strb=4'b0100 with din channel 2 = 1, ready=1 -> next edge: valid=1, Sel=2, Y=1, pending=0. The following edge: valid=0.
2. strb=4'b1111 for one cycle with din=4'b1010 (ch0=0, ch1=1, ch2=0, ch3=1), ready=1, p=0 -> Sel sequence is 0, 1, 2, 3 on four consecutive cycles, Y is 0, 1, 0, 1, valid stays high for 4 cycles, ovf=0.
3. Same load as test 2 with ready=0 for 3 cycles -> Sel=0, Y=0 held stable with valid=1. After ready goes to 1, the sequence resumes with Sel=1.
4. strb[1] pulses twice (din 1, then 0) while valid=1 and ready=0 -> ovf=4'b0010, and the word delivered for channel 1 is Y=0.
5. p=3 after a grant to channel 2, channels 0 and 3 pending -> grant order is 3 then 0 (wrap-around).
6. Assert reset asynchronously mid-cycle while valid=1 and pending=4'b0110 -> all outputs go to 0 immediately without a clock edge. After release, no stale word appears.
